// File: rtl/axi_mem_pkg.sv
// Shared encodings for the AXI memory slave: burst types, responses, FSM states.
// Also holds the per-burst context struct latched on AW/AR handshakes.
package axi_mem_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  typedef struct packed {
    burst_t     burst;
    logic [7:0] len;
  } burst_ctx_t;

  // WRAP bursts are only legal for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_mem_addr_gen.sv
// Next word index for a burst plus an error flag for the current beat.
// Purely combinational; no latency, no backpressure.
module axi_mem_addr_gen
  import axi_mem_pkg::*;
#(
  parameter int IDX_W = 14,
  parameter int DEPTH = 1024
) (
  input  logic [IDX_W-1:0] idx,
  input  logic [1:0]       burst,
  input  logic [7:0]       len,
  output logic [IDX_W-1:0] nxt,
  output logic             err
);

  logic [IDX_W-1:0] mask;
  logic [IDX_W-1:0] inc;
  logic             burst_bad;
  logic             range_bad;

  // For legal WRAP lengths, len itself is the low-bit mask of the aligned block.
  assign mask = IDX_W'(len);
  assign inc  = idx + IDX_W'(1);

  always_comb begin
    nxt = idx;
    case (burst)
      BURST_INCR: nxt = inc;
      BURST_WRAP: nxt = (idx & ~mask) | (inc & mask);
      default:    nxt = idx;
    endcase
  end

  assign burst_bad = (burst == BURST_RSVD) ||
                     ((burst == BURST_WRAP) && !wrap_len_ok(len));
  assign range_bad = ({1'b0, idx} >= (IDX_W+1)'(DEPTH));
  assign err       = burst_bad || range_bad;

endmodule

// File: rtl/axi_mem_slave.sv
// AXI memory slave: independent write (AW/W/B) and read (AR/R) FSMs over one word array.
// First R beat one cycle after AR; R outputs hold under rready=0; bvalid holds until bready.
module axi_mem_slave
  import axi_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int ID_W   = 4,
  parameter int DEPTH  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_W-1:0]       awid,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic [7:0]            awlen,
  input  logic [1:0]            awburst,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [ID_W-1:0]       bid,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ID_W-1:0]       arid,
  input  logic [ADDR_W-1:0]     araddr,
  input  logic [7:0]            arlen,
  input  logic [1:0]            arburst,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [ID_W-1:0]       rid,
  output logic [DATA_W-1:0]     rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_W - OFF_W;
  localparam int MEM_AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic unused_lsb;
  assign unused_lsb = ^{awaddr[OFF_W-1:0], araddr[OFF_W-1:0]};

  // ---------------- write channel ----------------
  w_state_t         w_state;
  burst_ctx_t       w_ctx;
  logic [IDX_W-1:0] w_idx;
  logic [7:0]       w_cnt;
  logic             w_err;
  logic [ID_W-1:0]  w_id;
  logic [IDX_W-1:0] w_nxt;
  logic             w_beat_err;
  logic             w_we;

  assign awready = (w_state == W_IDLE) && !rst;
  assign wready  = (w_state == W_DATA) && !rst;
  assign bvalid  = (w_state == W_RESP) && !rst;

  axi_mem_addr_gen #(
    .IDX_W (IDX_W),
    .DEPTH (DEPTH)
  ) u_w_gen (
    .idx   (w_idx),
    .burst (w_ctx.burst),
    .len   (w_ctx.len),
    .nxt   (w_nxt),
    .err   (w_beat_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_ctx   <= '0;
      w_idx   <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
      w_id    <= '0;
      bid     <= '0;
      bresp   <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awvalid) begin
            w_state <= W_DATA;
            w_id    <= awid;
            w_idx   <= awaddr[ADDR_W-1:OFF_W];
            w_ctx   <= '{burst: burst_t'(awburst), len: awlen};
            w_cnt   <= '0;
            w_err   <= 1'b0;
          end
        end
        W_DATA: begin
          if (wvalid) begin
            // The beat count alone closes the burst; a misplaced wlast only taints bresp.
            if (w_cnt == w_ctx.len) begin
              w_state <= W_RESP;
              bid     <= w_id;
              bresp   <= (w_err || w_beat_err || !wlast) ? RESP_SLVERR : RESP_OKAY;
            end else begin
              w_cnt <= w_cnt + 8'd1;
              w_idx <= w_nxt;
              w_err <= w_err || w_beat_err || wlast;
            end
          end
        end
        W_RESP: begin
          if (bready) w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign w_we = wready && wvalid && !w_beat_err;

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[w_idx[MEM_AW-1:0]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_t         r_state;
  burst_ctx_t       r_ctx;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_cnt;
  logic [IDX_W-1:0] rg_idx;
  logic [1:0]       rg_burst;
  logic [7:0]       rg_len;
  logic [IDX_W-1:0] rg_nxt;
  logic             rg_err;
  logic [DATA_W-1:0] rd_word;

  assign arready = (r_state == R_IDLE) && !rst;
  assign rvalid  = (r_state == R_DATA) && !rst;

  // In idle the generator looks at the AR fields so beat 0 is fetched on the handshake;
  // afterwards r_idx already holds the index of the next beat to present.
  always_comb begin
    rg_idx   = r_idx;
    rg_burst = r_ctx.burst;
    rg_len   = r_ctx.len;
    if (r_state == R_IDLE) begin
      rg_idx   = araddr[ADDR_W-1:OFF_W];
      rg_burst = arburst;
      rg_len   = arlen;
    end
  end

  axi_mem_addr_gen #(
    .IDX_W (IDX_W),
    .DEPTH (DEPTH)
  ) u_r_gen (
    .idx   (rg_idx),
    .burst (rg_burst),
    .len   (rg_len),
    .nxt   (rg_nxt),
    .err   (rg_err)
  );

  assign rd_word = rg_err ? '0 : mem[rg_idx[MEM_AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_ctx   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
      rlast   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid) begin
            r_state <= R_DATA;
            r_ctx   <= '{burst: burst_t'(arburst), len: arlen};
            r_idx   <= rg_nxt;
            r_cnt   <= '0;
            rid     <= arid;
            rdata   <= rd_word;
            rresp   <= rg_err ? RESP_SLVERR : RESP_OKAY;
            rlast   <= (arlen == 8'd0);
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast) begin
              r_state <= R_IDLE;
              rlast   <= 1'b0;
            end else begin
              r_idx <= rg_nxt;
              r_cnt <= r_cnt + 8'd1;
              rdata <= rd_word;
              rresp <= rg_err ? RESP_SLVERR : RESP_OKAY;
              rlast <= ((r_cnt + 8'd1) == r_ctx.len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Scoreboard bench for axi_mem_slave: expected B/R responses queued at stimulus time.
// A reference word array tracks memory; burst addressing is modelled independently.
module tb_axi_mem_slave;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;
  localparam int ID_W   = 4;
  localparam int DEPTH  = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  awid;
  logic [15:0] awaddr;
  logic [7:0]  awlen;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  arid;
  logic [15:0] araddr;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  always #5 clk = ~clk;

  axi_mem_slave #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .ID_W   (ID_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .awid    (awid),
    .awaddr  (awaddr),
    .awlen   (awlen),
    .awburst (awburst),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wlast   (wlast),
    .wvalid  (wvalid),
    .wready  (wready),
    .bid     (bid),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready),
    .arid    (arid),
    .araddr  (araddr),
    .arlen   (arlen),
    .arburst (arburst),
    .arvalid (arvalid),
    .arready (arready),
    .rid     (rid),
    .rdata   (rdata),
    .rresp   (rresp),
    .rlast   (rlast),
    .rvalid  (rvalid),
    .rready  (rready)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] model [DEPTH];

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  rbeat_t r_exp[$];
  bexp_t  b_exp[$];

  function automatic int beat_idx(int start, int beat, int len, int burst);
    int n;
    int base;
    n = len + 1;
    if (burst == 0) return start;
    if (burst == 2) begin
      base = start - (start % n);
      return base + ((start % n) + beat) % n;
    end
    return start + beat;
  endfunction

  function automatic bit beat_err(int idx, int len, int burst);
    if (burst == 3) return 1'b1;
    if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b1;
    return idx >= DEPTH;
  endfunction

  task automatic wr_burst(input logic [3:0] id, input logic [15:0] addr, input int len,
                          input int burst, input logic [3:0] strb, input logic [31:0] dbase,
                          input int last_at);
    int    start;
    int    idx;
    int    cnt;
    bit    err;
    bexp_t e;
    bexp_t got;
    logic [31:0] d;
    start = int'(addr) >> 2;
    err   = (last_at != len);
    for (int b = 0; b <= len; b++) begin
      idx = beat_idx(start, b, len, burst);
      d   = dbase + 32'(b);
      if (beat_err(idx, len, burst)) err = 1'b1;
      else for (int k = 0; k < 4; k++) if (strb[k]) model[idx][8*k +: 8] = d[8*k +: 8];
    end
    e.id   = id;
    e.resp = err ? 2'b10 : 2'b00;
    b_exp.push_back(e);

    awid = id; awaddr = addr; awlen = 8'(len); awburst = 2'(burst); awvalid = 1'b1;
    cnt = 0;
    while (!awready && cnt < 50) begin @(posedge clk); #1; cnt++; end
    if (!awready) begin
      vectors++; miscompares++;
      $display("FAIL aw_timeout id=%0h: awready got %0b required 1", id, awready);
      awvalid = 1'b0; b_exp.delete(); return;
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      wdata = dbase + 32'(b); wstrb = strb; wlast = (b == last_at); wvalid = 1'b1;
      cnt = 0;
      while (!wready && cnt < 50) begin @(posedge clk); #1; cnt++; end
      if (!wready) begin
        vectors++; miscompares++;
        $display("FAIL w_timeout beat %0d: wready got %0b required 1", b, wready);
        wvalid = 1'b0; b_exp.delete(); return;
      end
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    cnt = 0;
    while (!bvalid && cnt < 50) begin @(posedge clk); #1; cnt++; end
    if (!bvalid) begin
      vectors++; miscompares++;
      $display("FAIL b_timeout id=%0h: bvalid got %0b required 1", id, bvalid);
      b_exp.delete();
    end else begin
      got = b_exp.pop_front();
      vectors++;
      if (bid !== got.id) begin
        miscompares++;
        $display("FAIL bid: got %0h required %0h", bid, got.id);
      end
      vectors++;
      if (bresp !== got.resp) begin
        miscompares++;
        $display("FAIL bresp id=%0h addr=%h: got %0h required %0h", id, addr, bresp, got.resp);
      end
    end
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic rd_burst(input logic [3:0] id, input logic [15:0] addr, input int len,
                          input int burst, input logic [3:0] pat);
    int     start;
    int     idx;
    int     cnt;
    int     beat;
    bit     held;
    rbeat_t e;
    rbeat_t got;
    rbeat_t hv;
    rbeat_t cur;
    start = int'(addr) >> 2;
    for (int b = 0; b <= len; b++) begin
      idx    = beat_idx(start, b, len, burst);
      e.id   = id;
      e.last = (b == len);
      if (beat_err(idx, len, burst)) begin e.data = '0; e.resp = 2'b10; end
      else begin e.data = model[idx]; e.resp = 2'b00; end
      r_exp.push_back(e);
    end

    arid = id; araddr = addr; arlen = 8'(len); arburst = 2'(burst); arvalid = 1'b1;
    cnt = 0;
    while (!arready && cnt < 50) begin @(posedge clk); #1; cnt++; end
    if (!arready) begin
      vectors++; miscompares++;
      $display("FAIL ar_timeout id=%0h: arready got %0b required 1", id, arready);
      arvalid = 1'b0; r_exp.delete(); return;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    vectors++;
    if (rvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL first_rvalid id=%0h: rvalid got %0b required 1 one cycle after AR", id, rvalid);
    end

    beat = 0; cnt = 0; held = 1'b0; hv = '0;
    while (beat <= len && cnt < 300) begin
      rready = pat[cnt % 4];
      if (rvalid === 1'b1) begin
        cur = {rid, rdata, rresp, rlast};
        if (held) begin
          vectors++;
          if (cur !== hv) begin
            miscompares++;
            $display("FAIL r_stable beat %0d: got %h required %h", beat, cur, hv);
          end
        end
        if (rready) begin
          got = r_exp.pop_front();
          vectors++;
          if (cur !== got) begin
            miscompares++;
            $display("FAIL rbeat %0d addr=%h: got rid=%0h data=%h resp=%0h last=%0b, required rid=%0h data=%h resp=%0h last=%0b",
                     beat, addr, rid, rdata, rresp, rlast, got.id, got.data, got.resp, got.last);
          end
          beat++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          hv   = cur;
        end
      end
      @(posedge clk); #1;
      cnt++;
    end
    rready = 1'b0;
    if (beat <= len) begin
      vectors++; miscompares++;
      $display("FAIL r_timeout id=%0h: beats got %0d required %0d", id, beat, len + 1);
      r_exp.delete();
    end else if (pat == 4'b1111) begin
      vectors++;
      if (cnt != len + 1) begin
        miscompares++;
        $display("FAIL r_rate id=%0h: cycles got %0d required %0d", id, cnt, len + 1);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_hs: got %b required 000000", {awready, wready, bvalid, arready, rvalid, rlast});
    end
    vectors++;
    if ({bid, bresp, rid, rdata, rresp} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got bid=%0h bresp=%0h rid=%0h rdata=%h rresp=%0h required all 0",
               bid, bresp, rid, rdata, rresp);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if ({awready, arready} !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_release: awready,arready got %b required 11", {awready, arready});
    end
  endtask

  task automatic test_init_mem;
    for (int s = 0; s < 4; s++)
      wr_burst(4'h0, 16'(s * 1024), 255, 1, 4'hF, 32'h5A00_0000 + 32'(s * 256), 255);
  endtask

  task automatic test_incr;
    wr_burst(4'h1, 16'h0010, 3, 1, 4'hF, 32'd1, 3);
    rd_burst(4'h1, 16'h0010, 3, 1, 4'hF);
  endtask

  task automatic test_wrap;
    rd_burst(4'h2, 16'h000C, 3, 2, 4'hF);
    wr_burst(4'h3, 16'h0028, 3, 2, 4'hF, 32'hC0DE_0000, 3);
    rd_burst(4'h3, 16'h0020, 3, 1, 4'hF);
  endtask

  task automatic test_strobe;
    wr_burst(4'h4, 16'h0040, 0, 1, 4'hF, 32'h1122_3344, 0);
    wr_burst(4'h4, 16'h0040, 0, 1, 4'b0001, 32'hAABB_CCDD, 0);
    wr_burst(4'h4, 16'h0044, 0, 1, 4'b1010, 32'hFFEE_DDCC, 0);
    rd_burst(4'h4, 16'h0040, 1, 1, 4'hF);
  endtask

  task automatic test_fixed;
    wr_burst(4'h5, 16'h0060, 2, 0, 4'hF, 32'h0F1E_0000, 2);
    rd_burst(4'h5, 16'h0060, 2, 0, 4'hF);
    rd_burst(4'h5, 16'h0060, 1, 1, 4'hF);
  endtask

  task automatic test_range_err;
    wr_burst(4'h6, 16'h0FF8, 3, 1, 4'hF, 32'hBAD0_0000, 3);
    rd_burst(4'h6, 16'h0FF8, 3, 1, 4'hF);
    rd_burst(4'h6, 16'h0000, 1, 1, 4'hF);
  endtask

  task automatic test_burst_err;
    wr_burst(4'h7, 16'h0080, 1, 3, 4'hF, 32'hDEAD_0000, 1);
    rd_burst(4'h7, 16'h0080, 1, 3, 4'hF);
    wr_burst(4'h7, 16'h0090, 2, 2, 4'hF, 32'hBEEF_0000, 2);
    rd_burst(4'h7, 16'h0090, 2, 2, 4'hF);
    rd_burst(4'h7, 16'h0080, 7, 1, 4'hF);
  endtask

  task automatic test_wlast;
    wr_burst(4'h8, 16'h00A0, 3, 1, 4'hF, 32'h0A0A_0000, 1);
    wr_burst(4'h8, 16'h00B0, 1, 1, 4'hF, 32'h0B0B_0000, 5);
    rd_burst(4'h8, 16'h00A0, 5, 1, 4'hF);
  endtask

  task automatic test_rready_toggle;
    rd_burst(4'h9, 16'h0010, 3, 1, 4'b1001);
    rd_burst(4'h9, 16'h0020, 3, 2, 4'b0110);
  endtask

  task automatic test_single_beat;
    wr_burst(4'hA, 16'h00C0, 0, 1, 4'hF, 32'h5151_5151, 0);
    rd_burst(4'hA, 16'h00C0, 0, 1, 4'hF);
    rd_burst(4'hA, 16'h00C4, 0, 2, 4'hF);
  endtask

  task automatic test_reset_mid_burst;
    int  cnt;
    bit  seen_b;
    awid = 4'hB; awaddr = 16'h0100; awlen = 8'd3; awburst = 2'b01; awvalid = 1'b1;
    cnt = 0;
    while (!awready && cnt < 50) begin @(posedge clk); #1; cnt++; end
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      wdata = 32'h7700_0000 + 32'(b); wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
      cnt = 0;
      while (!wready && cnt < 50) begin @(posedge clk); #1; cnt++; end
      if (wready) model[64 + b] = 32'h7700_0000 + 32'(b);
      @(posedge clk); #1;
    end
    wdata = 32'h7700_0002; wvalid = 1'b1; bready = 1'b1; rst = 1'b1;
    #1;
    vectors++;
    if ({awready, wready, bvalid} !== 3'b000) begin
      miscompares++;
      $display("FAIL mid_rst_hold: awready,wready,bvalid got %b required 000", {awready, wready, bvalid});
    end
    @(posedge clk); #1;
    rst = 1'b0; wvalid = 1'b0;
    #1;
    vectors++;
    if ({awready, bvalid} !== 2'b10) begin
      miscompares++;
      $display("FAIL mid_rst_release: awready,bvalid got %b required 10", {awready, bvalid});
    end
    seen_b = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bvalid !== 1'b0) seen_b = 1'b1;
    end
    vectors++;
    if (seen_b) begin
      miscompares++;
      $display("FAIL mid_rst_no_b: bvalid seen got 1 required 0");
    end
    bready = 1'b0;
    rd_burst(4'hB, 16'h0100, 3, 1, 4'hF);
    wr_burst(4'hC, 16'h0100, 3, 1, 4'hF, 32'h7800_0000, 3);
    rd_burst(4'hC, 16'h0100, 3, 1, 4'hF);
  endtask

  task automatic test_back_to_back;
    fork
      wr_burst(4'hD, 16'h0200, 7, 1, 4'hF, 32'h9900_0000, 7);
      rd_burst(4'hE, 16'h0300, 7, 1, 4'hF);
    join
    rd_burst(4'hD, 16'h0200, 7, 1, 4'hF);
    rd_burst(4'hF, 16'h0204, 3, 2, 4'hF);
  endtask

  initial begin
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    test_reset;
    test_init_mem;
    test_incr;
    test_wrap;
    test_strobe;
    test_fixed;
    test_range_err;
    test_burst_err;
    test_wlast;
    test_rready_toggle;
    test_single_beat;
    test_reset_mid_burst;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule

// File: doc/axi_mem_slave.md
AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data bus width in bits (32/64/128).
REQ-002 SHALL have parameter ADDR_W, default 16, byte-address width.
REQ-003 SHALL have parameter ID_W, default 4, transaction ID width.
REQ-004 SHALL have parameter DEPTH, default 1024, memory depth in DATA_W words.
REQ-005 SHALL have a single clock and a synchronous, active-high reset.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 awid  in  ID_W  write ID.
REQ-009 awaddr  in  ADDR_W  write start byte address.
REQ-010 awlen  in  8  write beats minus 1.
REQ-011 awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
REQ-012 awvalid / awready  in / out  1  AW handshake.
REQ-013 wdata  in  DATA_W  write data.
REQ-014 wstrb  in  DATA_W/8  byte enables.
REQ-015 wlast  in  1  final write beat marker.
REQ-016 wvalid / wready  in / out  1  W handshake.
REQ-017 bid  out  ID_W  echoed awid.
REQ-018 bresp  out  2  00 OKAY, 10 SLVERR.
REQ-019 bvalid / bready  out / in  1  B handshake.
REQ-020 arid, araddr, arlen, arburst  in  ID_W, ADDR_W, 8, 2  read address fields, same encoding as AW.
REQ-021 arvalid / arready  in / out  1  AR handshake.
REQ-022 rid, rdata, rresp, rlast  out  ID_W, DATA_W, 2, 1  read data fields.
REQ-023 rvalid / rready  out / in  1  R handshake.

Function
REQ-024 Write FSM SHALL use states W_IDLE -> W_DATA (AW handshake; id/addr/len/burst latched) -> W_RESP (beat count == awlen accepted) -> W_IDLE (B handshake); awready=1 only in W_IDLE, wready=1 only in W_DATA, bvalid=1 only in W_RESP, held until bready.
REQ-025 Each accepted W beat SHALL write only the bytes with wstrb=1 into word index (addr >> log2(DATA_W/8)); all transfers are full DATA_W width.
REQ-026 Next-address rule: FIXED unchanged; INCR +1 word; WRAP +1 word, wrapping within the (len+1)-word block aligned to (len+1) words.
REQ-027 Burst SLVERR conditions: burst=11, WRAP with len not in {1,3,7,15}, or any beat index >= DEPTH; erroneous beats SHALL not write and read rdata=0.
REQ-028 bresp SHALL be SLVERR when any beat erred or wlast disagreed with the beat count; beat count alone ends the burst.
REQ-029 Read FSM SHALL use states R_IDLE -> R_DATA (AR handshake) -> R_IDLE (handshake of beat with rlast=1); arready=1 only in R_IDLE.
REQ-030 First rvalid SHALL assert exactly 1 cycle after AR handshake; with rready held high, beats SHALL issue 1 per cycle; rid/rdata/rresp/rlast SHALL stay stable while rvalid=1 and rready=0.
REQ-031 rresp SHALL be per beat; rlast=1 only on beat arlen.
REQ-032 Read and write channels SHALL operate concurrently; a read of a word written in the same cycle SHALL return pre-write data.
REQ-033 awlen=0 / arlen=0 SHALL produce a single-beat burst, with wlast/rlast on beat 0.

Reset
REQ-034 During rst: FSMs to IDLE; awready, wready, bvalid, arready, rvalid, rlast = 0; bid, bresp, rid, rdata, rresp = 0; awready/arready = 1 from the first cycle after rst deasserts; rst mid-burst aborts with no B/R issued; memory contents preserved.

Structure
REQ-035 Package axi_mem_pkg SHALL hold burst/resp encodings and the write/read state enums.
REQ-036 Sub-module axi_mem_addr_gen (next-word index + range/WRAP error flag) SHALL be instanced once per channel.

Verification
REQ-037 INCR, awaddr=0x10, awlen=3, wstrb=all 1s, data 1..4, then matching AR -> rdata 1,2,3,4, rlast on beat 3, bresp=rresp=OKAY.
REQ-038 WRAP, araddr=0x0C, arlen=3, DATA_W=32 -> word indices 3,0,1,2 read in that order.
REQ-039 Write wstrb=0001 with data 0xAABBCCDD over a word holding 0x11223344 -> readback 0x112233DD.
REQ-040 INCR, start word DEPTH-2, len=3 -> beats 2-3 rresp=SLVERR, rdata=0; write bresp=SLVERR; words 0-1 not corrupted.
REQ-041 rready toggled 1,0,0,1 during a 4-beat read -> each beat held stable, no beat lost or duplicated.
REQ-042 rst pulsed during W_DATA at beat 2 of 4 -> no bvalid, awready=1 the cycle after rst, next burst completes OKAY.
